wb_byte_master: RTL

Byte-stream-driven Wishbone initiator: parses a small command protocol arriving on an 8-bit valid/ready stream and issues single 32-bit Wishbone read/write cycles into the SoC data bus. It sits between a UART receiver/transmitter pair and the data-bus master port of the SoC, in parallel with the CPU dbus. It is used for debug access and RAM loading without the CPU. Read data and status bytes are returned on an outbound byte stream.

---
 rtl/wb_byte_pkg.sv | 28 ++
 rtl/wb_byte_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_byte_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_byte_pkg
// Description : Shared constants and FSM encoding for the byte-stream
//               Wishbone initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_byte_pkg;

    // Command bytes recognised in IDLE
    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W' + 4 addr + 4 data
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R' + 4 addr

    // Single-byte status responses
    localparam logic [7:0] RSP_ACK = 8'h06;  // write completed
    localparam logic [7:0] RSP_NAK = 8'h15;  // bus cycle abandoned

    // Protocol / bus FSM
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

endpackage : wb_byte_pkg
`default_nettype wire

// File: rtl/wb_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_byte_master
// Description : Parses 'W'/'R' commands from an 8-bit valid/ready stream,
//               issues single 32-bit Wishbone cycles and returns status or
//               read data on an outbound byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_byte_master
    import wb_byte_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255   // 1..65535 cycles without ack
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    // inbound command stream
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    // outbound response stream
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    // Wishbone initiator
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat,
    output logic [3:0]  wb_sel,
    output logic        wb_we,
    output logic        wb_cyc,
    input  logic [31:0] wb_rdt,
    input  logic        wb_ack,
    // status
    output logic        busy,
    output logic        err
);

    // Last timeout count value before the cycle is abandoned
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [1:0]  cnt_q;      // byte index shared by ADDR/DATA/RESP
    logic [1:0]  last_q;     // index of final response byte
    logic [15:0] tmo_q;      // cycles spent in BUS without ack
    logic [31:0] shift_q;    // remaining response bytes, MSB first
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        we_q;
    logic        cyc_q;
    logic        txv_q;
    logic [7:0]  txd_q;
    logic        err_q;

    logic        w_in_rx;
    logic        w_rx_fire;

    // Only the parsing states take input; gated by reset so nothing is
    // claimed to be accepted while the block is held in reset.
    assign w_in_rx   = (state_q == ST_IDLE) || (state_q == ST_ADDR) ||
                       (state_q == ST_DATA);
    assign rx_ready  = w_in_rx & ~wb_rst;
    assign w_rx_fire = rx_valid & rx_ready;
    assign busy      = (state_q != ST_IDLE);
    assign wb_sel    = 4'hF;

    assign wb_adr   = adr_q;
    assign wb_dat   = dat_q;
    assign wb_we    = we_q;
    assign wb_cyc   = cyc_q;
    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign err      = err_q;

    // Command parser, bus sequencer and response serializer
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            tmo_q   <= 16'd0;
            shift_q <= 32'd0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Unknown bytes are consumed and dropped here
                    if (w_rx_fire && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                        we_q    <= (rx_data == CMD_WR);
                        cnt_q   <= 2'd0;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_rx_fire) begin
                        adr_q <= {adr_q[23:0], rx_data};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (we_q) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q <= ST_BUS;
                                cyc_q   <= 1'b1;
                                tmo_q   <= 16'd0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_rx_fire) begin
                        dat_q <= {dat_q[23:0], rx_data};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= ST_BUS;
                            cyc_q   <= 1'b1;
                            tmo_q   <= 16'd0;
                        end
                    end
                end
                ST_BUS: begin
                    // An ack in the same cycle as the limit still completes
                    if (wb_ack) begin
                        cyc_q   <= 1'b0;
                        txv_q   <= 1'b1;
                        cnt_q   <= 2'd0;
                        state_q <= ST_RESP;
                        if (we_q) begin
                            txd_q  <= RSP_ACK;
                            last_q <= 2'd0;
                        end else begin
                            txd_q   <= wb_rdt[31:24];
                            shift_q <= {wb_rdt[23:0], 8'h00};
                            last_q  <= 2'd3;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        cyc_q   <= 1'b0;
                        txv_q   <= 1'b1;
                        txd_q   <= RSP_NAK;
                        cnt_q   <= 2'd0;
                        last_q  <= 2'd0;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                ST_RESP: begin
                    // tx_data/tx_valid hold until the sink takes the byte
                    if (tx_ready) begin
                        if (cnt_q == last_q) begin
                            txv_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            txd_q   <= shift_q[31:24];
                            shift_q <= {shift_q[23:0], 8'h00};
                            cnt_q   <= cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : wb_byte_master
`default_nettype wire
